// File: rtl/gpu_mem_pkg.sv
// Shared types and default widths for the LSU data-memory arbiter.
package gpu_mem_pkg;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_WAITING  = 2'd1,
        WRITE_WAITING = 2'd2,
        RELAYING      = 2'd3
    } arb_state_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsu_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_picker
    import gpu_mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          found,
    output logic [IW-1:0] index
);

    logic [IW-1:0] cand_s;

    // Scan offsets 1..N from last_grant so last_grant itself is checked last.
    always_comb begin
        found  = 1'b0;
        index  = '0;
        cand_s = '0;
        for (int i = 1; i <= N; i++) begin
            cand_s = IW'((int'(last_grant) + i) % N);
            if (!found && req[cand_s]) begin
                found = 1'b1;
                index = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory read/write channel among NUM_CONSUMERS LSUs, round-robin.
// Optional macro LSU_ARB_TIMEOUT_EN adds a wait watchdog and sticky timeout_error output.
module lsu_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CONSUMERS  = 4,
    parameter int ADDR_BITS      = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic                                    mem_read_valid,
    output logic [ADDR_BITS-1:0]                    mem_read_address,
    input  logic                                    mem_read_ready,
    input  logic [DATA_BITS-1:0]                    mem_read_data,
    output logic                                    mem_write_valid,
    output logic [ADDR_BITS-1:0]                    mem_write_address,
    output logic [DATA_BITS-1:0]                    mem_write_data,
    input  logic                                    mem_write_ready
`ifdef LSU_ARB_TIMEOUT_EN
    ,
    output logic                                    timeout_error
`endif
);

    localparam int IW = idx_bits(NUM_CONSUMERS);

    arb_state_t                              state_q, state_d;
    logic [IW-1:0]                           grant_q, grant_d;
    logic [IW-1:0]                           last_grant_q, last_grant_d;
    logic                                    mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]                    mem_read_address_q, mem_read_address_d;
    logic                                    mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]                    mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]                    mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]                read_ready_q, read_ready_d;
    logic [NUM_CONSUMERS-1:0]                write_ready_q, write_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_q, read_data_d;
    logic                                    pick_found_s;
    logic [IW-1:0]                           pick_index_s;
    logic                                    relay_done_s;

`ifdef LSU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_error_q, timeout_error_d;
    assign timeout_error = timeout_error_q;
`else
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg
    end
`endif

    rr_picker #(.N(NUM_CONSUMERS), .IW(IW)) u_picker (
        .req        (consumer_read_valid | consumer_write_valid),
        .last_grant (last_grant_q),
        .found      (pick_found_s),
        .index      (pick_index_s)
    );

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        last_grant_d        = last_grant_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        read_ready_d        = read_ready_q;
        write_ready_d       = write_ready_q;
        read_data_d         = read_data_q;
`ifdef LSU_ARB_TIMEOUT_EN
        wait_cnt_d          = wait_cnt_q;
        timeout_error_d     = timeout_error_q;
`endif
        // A read-served relay ends on read_valid dropping, a write-served one on write_valid.
        if (|read_ready_q) begin
            relay_done_s = !consumer_read_valid[grant_q];
        end else begin
            relay_done_s = !consumer_write_valid[grant_q];
        end
        case (state_q)
            IDLE: begin
`ifdef LSU_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                if (pick_found_s) begin
                    grant_d      = pick_index_s;
                    last_grant_d = pick_index_s;
                    if (consumer_read_valid[pick_index_s]) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[pick_index_s];
                        state_d            = READ_WAITING;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[pick_index_s];
                        mem_write_data_d    = consumer_write_data[pick_index_s];
                        state_d             = WRITE_WAITING;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    mem_read_valid_d      = 1'b0;
                    read_data_d[grant_q]  = mem_read_data;
                    read_ready_d[grant_q] = 1'b1;
                    state_d               = RELAYING;
                end else begin
`ifdef LSU_ARB_TIMEOUT_EN
                    if (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        mem_read_valid_d = 1'b0;
                        timeout_error_d  = 1'b1;
                        state_d          = IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
`else
                    state_d = READ_WAITING;
`endif
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mem_write_valid_d      = 1'b0;
                    write_ready_d[grant_q] = 1'b1;
                    state_d                = RELAYING;
                end else begin
`ifdef LSU_ARB_TIMEOUT_EN
                    if (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        mem_write_valid_d = 1'b0;
                        timeout_error_d   = 1'b1;
                        state_d           = IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
`else
                    state_d = WRITE_WAITING;
`endif
                end
            end
            RELAYING: begin
                if (relay_done_s) begin
                    read_ready_d  = '0;
                    write_ready_d = '0;
                    state_d       = IDLE;
                end else begin
                    state_d = RELAYING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset acts immediately, even mid-transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= IDLE;
            grant_q             <= '0;
            last_grant_q        <= IW'(NUM_CONSUMERS - 1);
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            read_ready_q        <= '0;
            write_ready_q       <= '0;
            read_data_q         <= '0;
`ifdef LSU_ARB_TIMEOUT_EN
            wait_cnt_q          <= '0;
            timeout_error_q     <= 1'b0;
`endif
        end else begin
            state_q             <= state_d;
            grant_q             <= grant_d;
            last_grant_q        <= last_grant_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            read_ready_q        <= read_ready_d;
            write_ready_q       <= write_ready_d;
            read_data_q         <= read_data_d;
`ifdef LSU_ARB_TIMEOUT_EN
            wait_cnt_q          <= wait_cnt_d;
            timeout_error_q     <= timeout_error_d;
`endif
        end
    end

    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign consumer_read_ready  = read_ready_q;
    assign consumer_write_ready = write_ready_q;
    assign consumer_read_data   = read_data_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Scoreboard bench for lsu_mem_arbiter: a memory responder and a consumer-side monitor pop expected events.
module tb_lsu_mem_arbiter;

    typedef struct packed {
        logic       is_write;
        logic [7:0] addr;
        logic [7:0] data;
    } mem_ev_t;

    typedef struct packed {
        logic       is_write;
        logic [1:0] cons;
        logic [7:0] data;
        logic [3:0] hi;
    } cons_ev_t;

    logic            clk;
    logic            reset;
    logic [3:0]      consumer_read_valid;
    logic [3:0][7:0] consumer_read_address;
    logic [3:0]      consumer_read_ready;
    logic [3:0][7:0] consumer_read_data;
    logic [3:0]      consumer_write_valid;
    logic [3:0][7:0] consumer_write_address;
    logic [3:0][7:0] consumer_write_data;
    logic [3:0]      consumer_write_ready;
    logic            mem_read_valid;
    logic [7:0]      mem_read_address;
    logic            mem_read_ready;
    logic [7:0]      mem_read_data;
    logic            mem_write_valid;
    logic [7:0]      mem_write_address;
    logic [7:0]      mem_write_data;
    logic            mem_write_ready;
`ifdef LSU_ARB_TIMEOUT_EN
    logic            timeout_error;
`endif

    int       n_vec = 0;
    int       n_fail = 0;
    int       mem_lat = 1;
    int       hold[4];
    mem_ev_t  exp_mem[$];
    cons_ev_t exp_cons[$];

    lsu_mem_arbiter dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
`ifdef LSU_ARB_TIMEOUT_EN
        ,
        .timeout_error          (timeout_error)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got event %0h, required none", name, act);
    endtask

    task automatic exp_txn(input logic w, input logic [1:0] c, input logic [7:0] a,
                           input logic [7:0] d, input logic [3:0] h);
        mem_ev_t  m;
        cons_ev_t e;
        m.is_write = w;
        m.addr     = a;
        m.data     = w ? d : 8'h00;
        e.is_write = w;
        e.cons     = c;
        e.data     = d;
        e.hi       = h;
        exp_mem.push_back(m);
        exp_cons.push_back(e);
    endtask

    task automatic mem_check(input logic w, input logic [7:0] a, input logic [7:0] d);
        mem_ev_t m;
        if (exp_mem.size() == 0) begin
            unexpected("mem_unexpected", {23'd0, w, a});
        end else begin
            m = exp_mem.pop_front();
            chk("mem_is_write", w, m.is_write);
            chk("mem_address", a, m.addr);
            if (w) chk("mem_write_data", d, m.data);
        end
    endtask

    // Memory responder: answers each request after mem_lat cycles and scores the accepted request.
    initial begin
        int rcnt;
        int wcnt;
        rcnt = 0;
        wcnt = 0;
        mem_read_ready  = 1'b0;
        mem_read_data   = 8'h00;
        mem_write_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rcnt = 0;
                wcnt = 0;
                mem_read_ready  = 1'b0;
                mem_read_data   = 8'h00;
                mem_write_ready = 1'b0;
            end else begin
                if (mem_read_ready) begin
                    mem_read_ready = 1'b0;
                    mem_read_data  = 8'h00;
                end else if (mem_read_valid) begin
                    rcnt++;
                    if (rcnt >= mem_lat) begin
                        rcnt = 0;
                        mem_read_ready = 1'b1;
                        mem_read_data  = mem_read_address ^ 8'hBB;
                        mem_check(1'b0, mem_read_address, 8'h00);
                    end
                end
                if (mem_write_ready) begin
                    mem_write_ready = 1'b0;
                end else if (mem_write_valid) begin
                    wcnt++;
                    if (wcnt >= mem_lat) begin
                        wcnt = 0;
                        mem_write_ready = 1'b1;
                        mem_check(1'b1, mem_write_address, mem_write_data);
                    end
                end
            end
        end
    end

    // Consumer-side monitor: scores each completion and how long its ready line stays high.
    initial begin
        logic [3:0] prev;
        logic [3:0] rdy;
        int         hi[4];
        int         exp_hi[4];
        cons_ev_t   e;
        prev = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            hi[i]     = 0;
            exp_hi[i] = 1;
        end
        forever begin
            @(negedge clk);
            rdy = consumer_read_ready | consumer_write_ready;
            if (reset) begin
                prev = 4'b0000;
            end else begin
                if (rdy != 4'b0000) chk("ready_at_most_one", $countones(rdy), 1);
                if (mem_read_valid && mem_write_valid) unexpected("mem_both_valid", 2);
                for (int i = 0; i < 4; i++) begin
                    if (rdy[i] && !prev[i]) begin
                        hi[i] = 1;
                        if (exp_cons.size() == 0) begin
                            unexpected("cons_unexpected", i);
                        end else begin
                            e = exp_cons.pop_front();
                            chk("cons_index", i, e.cons);
                            chk("cons_is_write", consumer_write_ready[i], e.is_write);
                            if (!e.is_write) chk("cons_read_data", consumer_read_data[i], e.data);
                            exp_hi[i] = e.hi + 1;
                        end
                    end else if (rdy[i]) begin
                        hi[i]++;
                    end else if (prev[i]) begin
                        chk("ready_hold_cycles", hi[i], exp_hi[i]);
                    end
                end
                prev = rdy;
            end
        end
    end

    // One cycle of consumer behaviour: drop valid once ready has been seen for hold extra cycles.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (consumer_read_ready[i] && consumer_read_valid[i]) begin
                    if (hold[i] > 0) hold[i]--;
                    else consumer_read_valid[i] = 1'b0;
                end
                if (consumer_write_ready[i] && consumer_write_valid[i]) begin
                    if (hold[i] > 0) hold[i]--;
                    else consumer_write_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (exp_mem.size() == 0 && exp_cons.size() == 0 &&
                consumer_read_valid == 4'b0000 && consumer_write_valid == 4'b0000 &&
                consumer_read_ready == 4'b0000 && consumer_write_ready == 4'b0000) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_drained"}, done, 1);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset                  = 1'b1;
        consumer_read_valid    = 4'b0000;
        consumer_write_valid   = 4'b0000;
        consumer_read_address  = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        for (int i = 0; i < 4; i++) hold[i] = 0;

        tick();
        chk("rst_mem_read_valid", mem_read_valid, 0);
        chk("rst_mem_write_valid", mem_write_valid, 0);
        chk("rst_read_ready", consumer_read_ready, 0);
        chk("rst_write_ready", consumer_write_ready, 0);
        chk("rst_read_data", consumer_read_data, 0);
        chk("rst_mem_addrs", {mem_read_address, mem_write_address, mem_write_data}, 0);

        // Single read, memory answers after 3 cycles; address change after grant must be ignored.
        do_reset();
        mem_lat = 3;
        exp_txn(1'b0, 2'd2, 8'h10, 8'hAB, 4'd0);
        consumer_read_address[2] = 8'h10;
        consumer_read_valid[2]   = 1'b1;
        tick();
        chk("lat1_mem_read_valid", mem_read_valid, 1);
        chk("lat1_mem_read_address", mem_read_address, 8'h10);
        consumer_read_address[2] = 8'h77;
        tick();
        tick();
        tick();
        chk("single_read_ready", consumer_read_ready, 4'b0100);
        chk("single_read_data", consumer_read_data[2], 8'hAB);
        drain("single_read");

        // Four simultaneous reads, two rounds: order 0,1,2,3 both times.
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 4; i++) begin
            consumer_read_address[i] = 8'h40 + 8'(i);
            consumer_read_valid[i]   = 1'b1;
        end
        exp_txn(1'b0, 2'd0, 8'h40, 8'hFB, 4'd0);
        exp_txn(1'b0, 2'd1, 8'h41, 8'hFA, 4'd0);
        exp_txn(1'b0, 2'd2, 8'h42, 8'hF9, 4'd0);
        exp_txn(1'b0, 2'd3, 8'h43, 8'hF8, 4'd0);
        drain("rr_round1");
        for (int i = 0; i < 4; i++) begin
            consumer_read_address[i] = 8'h50 + 8'(i);
            consumer_read_valid[i]   = 1'b1;
        end
        exp_txn(1'b0, 2'd0, 8'h50, 8'hEB, 4'd0);
        exp_txn(1'b0, 2'd1, 8'h51, 8'hEA, 4'd0);
        exp_txn(1'b0, 2'd2, 8'h52, 8'hE9, 4'd0);
        exp_txn(1'b0, 2'd3, 8'h53, 8'hE8, 4'd0);
        drain("rr_round2");

        // Write from consumer 1 and read from consumer 3 together: write first, then read.
        do_reset();
        mem_lat = 2;
        consumer_write_address[1] = 8'h20;
        consumer_write_data[1]    = 8'h5A;
        consumer_write_valid[1]   = 1'b1;
        consumer_read_address[3]  = 8'h21;
        consumer_read_valid[3]    = 1'b1;
        exp_txn(1'b1, 2'd1, 8'h20, 8'h5A, 4'd0);
        exp_txn(1'b0, 2'd3, 8'h21, 8'h9A, 4'd0);
        tick();
        chk("wr_first_mem_write_valid", mem_write_valid, 1);
        consumer_write_data[1]    = 8'hFF;
        consumer_write_address[1] = 8'hEE;
        drain("write_then_read");
        consumer_read_address[1] = 8'h22;
        consumer_read_valid[1]   = 1'b1;
        exp_txn(1'b0, 2'd1, 8'h22, 8'h99, 4'd0);
        drain("later_read");
        chk("data_hold_c3", consumer_read_data[3], 8'h9A);
        chk("data_new_c1", consumer_read_data[1], 8'h99);

        // Consumer holds read_valid for 2 cycles after ready: one memory request only.
        do_reset();
        mem_lat = 1;
        hold[0] = 2;
        consumer_read_address[0] = 8'h60;
        consumer_read_valid[0]   = 1'b1;
        exp_txn(1'b0, 2'd0, 8'h60, 8'hDB, 4'd2);
        drain("held_valid");

        // Reset while waiting for memory: outputs clear at once, consumer 0 wins after release.
        do_reset();
        mem_lat = 20;
        consumer_read_address[2] = 8'h30;
        consumer_read_valid[2]   = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_rst_pre_valid", mem_read_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_mem_read_valid", mem_read_valid, 0);
        chk("mid_rst_ready", {consumer_read_ready, consumer_write_ready}, 0);
        chk("mid_rst_mem_read_address", mem_read_address, 0);
        mem_lat = 2;
        consumer_read_address[0] = 8'h31;
        consumer_read_valid[0]   = 1'b1;
        exp_txn(1'b0, 2'd0, 8'h31, 8'h8A, 4'd0);
        exp_txn(1'b0, 2'd2, 8'h30, 8'h8B, 4'd0);
        tick();
        reset = 1'b0;
        drain("after_mid_reset");

        chk("exp_mem_empty", exp_mem.size(), 0);
        chk("exp_cons_empty", exp_cons.size(), 0);
`ifdef LSU_ARB_TIMEOUT_EN
        chk("no_timeout", timeout_error, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
